// File: rtl/core_l1d_resp.sv
// rtl/core_l1d_resp.sv - data-side L1 responder: core load/store to word-aligned byte-enabled bus
module core_l1d_resp #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        l1d_val_in,
    input  logic        l1d_cop_in,
    input  logic [2:0]  l1d_size_in,
    input  logic [31:0] l1d_addr_in,
    input  logic [31:0] l1d_wdata_in,
    output logic        l1d_stall_out,
    output logic        l1d_ack_out,
    output logic        l1d_err_out,
    output logic [31:0] l1d_rdata_out,
    output logic        mem_req_out,
    output logic        mem_we_out,
    output logic [3:0]  mem_be_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_wdata_out,
    input  logic        mem_ack_in,
    input  logic [31:0] mem_rdata_in
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic        cop_q;
    logic        mem_req_q, mem_we_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic        size_ok, illegal, timeout_hit;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, load_shift, load_fmt;

    assign size_ok = (l1d_size_in == 3'b001) || (l1d_size_in == 3'b010) || (l1d_size_in == 3'b100);
    assign illegal = !size_ok
                   || (l1d_size_in[1] && l1d_addr_in[0])
                   || (l1d_size_in[2] && (l1d_addr_in[1:0] != 2'b00));
    // cnt_q counts completed wait cycles, so this REQ cycle is number cnt_q+1
    assign timeout_hit = (TIMEOUT != 0) && ((cnt_q + 32'd1) == TIMEOUT);

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = l1d_wdata_in;
        if (l1d_size_in[0]) begin
            be_d    = 4'b0001 << l1d_addr_in[1:0];
            wdata_d = {4{l1d_wdata_in[7:0]}};
        end else if (l1d_size_in[1]) begin
            be_d    = 4'b0011 << {l1d_addr_in[1], 1'b0};
            wdata_d = {2{l1d_wdata_in[15:0]}};
        end
    end

    // Lane-align and zero-extend; sign extension happens later in write-back
    assign load_shift = mem_rdata_in >> {off_q, 3'b000};
    assign load_fmt   = size_q[0] ? {24'b0, load_shift[7:0]}
                      : size_q[1] ? {16'b0, load_shift[15:0]}
                      : load_shift;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (l1d_val_in) state_d = illegal ? RESP : REQ;
            REQ:  if (mem_ack_in || timeout_hit) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            size_q      <= '0;
            off_q       <= '0;
            cop_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (l1d_val_in) begin
                        if (illegal) begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= l1d_cop_in;
                            mem_be_q    <= be_d;
                            mem_addr_q  <= {l1d_addr_in[31:2], 2'b00};
                            mem_wdata_q <= wdata_d;
                            size_q      <= l1d_size_in[1:0];
                            off_q       <= l1d_addr_in[1:0];
                            cop_q       <= l1d_cop_in;
                            err_q       <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack_in) begin
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b0;
                        rdata_q   <= cop_q ? 32'd0 : load_fmt;
                    end else if (timeout_hit) begin
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        rdata_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
            endcase
        end
    end

    assign l1d_stall_out = ((state_q == IDLE) && l1d_val_in) || (state_q == REQ);
    assign l1d_ack_out   = (state_q == RESP);
    assign l1d_err_out   = err_q;
    assign l1d_rdata_out = rdata_q;
    assign mem_req_out   = mem_req_q;
    assign mem_we_out    = mem_we_q;
    assign mem_be_out    = mem_be_q;
    assign mem_addr_out  = mem_addr_q;
    assign mem_wdata_out = mem_wdata_q;

endmodule

// File: tb/tb_core_l1d_resp.sv
// tb/tb_core_l1d_resp.sv - randomized self-checking bench for core_l1d_resp
module tb_core_l1d_resp;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        l1d_val_in, l1d_cop_in;
    logic [2:0]  l1d_size_in;
    logic [31:0] l1d_addr_in, l1d_wdata_in;
    logic        l1d_stall_out, l1d_ack_out, l1d_err_out;
    logic [31:0] l1d_rdata_out;
    logic        mem_req_out, mem_we_out;
    logic [3:0]  mem_be_out;
    logic [31:0] mem_addr_out, mem_wdata_out;
    logic        mem_ack_in;
    logic [31:0] mem_rdata_in;

    int n_checks = 0;
    int n_fail   = 0;

    core_l1d_resp #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .l1d_val_in(l1d_val_in), .l1d_cop_in(l1d_cop_in), .l1d_size_in(l1d_size_in),
        .l1d_addr_in(l1d_addr_in), .l1d_wdata_in(l1d_wdata_in),
        .l1d_stall_out(l1d_stall_out), .l1d_ack_out(l1d_ack_out),
        .l1d_err_out(l1d_err_out), .l1d_rdata_out(l1d_rdata_out),
        .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .mem_be_out(mem_be_out),
        .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
        .mem_ack_in(mem_ack_in), .mem_rdata_in(mem_rdata_in)
    );

    always #5 clk = ~clk;

    function automatic int nbytes_of(input logic [2:0] sz);
        if (sz == 3'b001) return 1;
        if (sz == 3'b010) return 2;
        if (sz == 3'b100) return 4;
        return 0;
    endfunction

    // waits: bus wait cycles before ack; negative means the bus never answers
    task automatic run_req(input logic [31:0] a, input logic [2:0] sz, input logic cop,
                           input logic [31:0] wd, input logic [31:0] bw, input int waits);
        int nb, off, e_req, e_resp, req_n, resp_at;
        logic bad, timed_out, e_err;
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_rd, e_addr;
        nb  = nbytes_of(sz);
        off = int'(a[1:0]);
        bad = (nb == 0) || ((off % ((nb == 0) ? 1 : nb)) != 0);
        e_addr = a & 32'hFFFF_FFFC;
        e_be = '0; e_wd = '0; e_rd = '0;
        if (!bad) begin
            for (int i = 0; i < 4; i++) begin
                e_be[i] = (i >= off) && (i < off + nb);
                e_wd[8*i +: 8] = wd[8*(i % nb) +: 8];
            end
            if (!cop)
                for (int j = 0; j < nb; j++) e_rd[8*j +: 8] = bw[8*(off + j) +: 8];
        end
        timed_out = !bad && ((waits < 0) || (waits + 1 > TO));
        e_err = bad || timed_out;
        if (e_err) e_rd = '0;
        e_req  = bad ? 0 : (timed_out ? TO : waits + 1);
        e_resp = bad ? 1 : e_req + 1;

        @(negedge clk);
        n_checks++;
        if (l1d_ack_out !== 1'b0 || mem_req_out !== 1'b0) begin
            n_fail++; $display("FAIL idle_gap: ack=%b req=%b required 0 0", l1d_ack_out, mem_req_out);
        end
        l1d_val_in = 1'b1; l1d_cop_in = cop; l1d_size_in = sz;
        l1d_addr_in = a; l1d_wdata_in = wd; mem_ack_in = 1'b0;
        #1;
        n_checks++;
        if (l1d_stall_out !== 1'b1) begin
            n_fail++; $display("FAIL stall_idle: got %b required 1", l1d_stall_out);
        end

        req_n = 0; resp_at = 0;
        for (int c = 1; c <= TO + 8 && resp_at == 0; c++) begin
            @(negedge clk);
            mem_ack_in = 1'b0; mem_rdata_in = $urandom;
            if (mem_req_out === 1'b1) begin
                req_n++;
                n_checks++;
                if (mem_addr_out !== e_addr || mem_be_out !== e_be || mem_we_out !== cop
                    || mem_wdata_out !== e_wd || l1d_stall_out !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bus_fields: addr=%h be=%b we=%b wd=%h stall=%b required %h %b %b %h 1",
                             mem_addr_out, mem_be_out, mem_we_out, mem_wdata_out, l1d_stall_out,
                             e_addr, e_be, cop, e_wd);
                end
                if (waits >= 0 && req_n == waits + 1) begin
                    mem_ack_in = 1'b1; mem_rdata_in = bw;
                end
            end
            if (l1d_ack_out === 1'b1) begin
                resp_at = c;
                n_checks++;
                if (l1d_err_out !== e_err || l1d_rdata_out !== e_rd || l1d_stall_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL resp: err=%b rdata=%h stall=%b required %b %h 0 (a=%h sz=%b)",
                             l1d_err_out, l1d_rdata_out, l1d_stall_out, e_err, e_rd, a, sz);
                end
                l1d_val_in = 1'b0;
            end
        end
        mem_ack_in = 1'b0;
        l1d_val_in = 1'b0;
        n_checks++;
        if (resp_at != e_resp || req_n != e_req) begin
            n_fail++;
            $display("FAIL timing: resp_cycle=%0d req_cycles=%0d required %0d %0d (a=%h sz=%b w=%0d)",
                     resp_at, req_n, e_resp, e_req, a, sz, waits);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; l1d_val_in = 1'b0; l1d_cop_in = 1'b0; l1d_size_in = '0;
        l1d_addr_in = '0; l1d_wdata_in = '0; mem_ack_in = 1'b0; mem_rdata_in = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({l1d_ack_out, l1d_err_out, l1d_rdata_out, mem_req_out, mem_we_out, mem_be_out,
             mem_addr_out, mem_wdata_out, l1d_stall_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ack=%b err=%b rd=%h req=%b we=%b be=%b addr=%h wd=%h stall=%b required all 0",
                     l1d_ack_out, l1d_err_out, l1d_rdata_out, mem_req_out, mem_we_out, mem_be_out,
                     mem_addr_out, mem_wdata_out, l1d_stall_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_req(32'h100, 3'b100, 1'b0, 32'h0, 32'hDEADBEEF, 0);
        run_req(32'h203, 3'b001, 1'b1, 32'h000000A5, 32'h0, 0);
        run_req(32'h302, 3'b010, 1'b0, 32'h0, 32'h80011234, 1);
        run_req(32'h401, 3'b100, 1'b0, 32'h0, 32'h0, 0);
        run_req(32'h501, 3'b010, 1'b1, 32'h1234, 32'h0, 0);
        run_req(32'h600, 3'b011, 1'b0, 32'h0, 32'h0, 0);
    endtask

    task automatic test_timeout();
        run_req(32'h700, 3'b100, 1'b0, 32'h0, 32'h11223344, -1);
        run_req(32'h704, 3'b100, 1'b0, 32'h0, 32'h55667788, TO - 1);
        run_req(32'h709, 3'b001, 1'b1, 32'hFFFFFF3C, 32'h0, TO);
    endtask

    task automatic test_reset_mid_req();
        @(negedge clk);
        l1d_val_in = 1'b1; l1d_cop_in = 1'b0; l1d_size_in = 3'b100;
        l1d_addr_in = 32'h800; mem_ack_in = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (mem_req_out !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_req: got %b required 1", mem_req_out);
        end
        rst = 1'b1; l1d_val_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_req_out !== 1'b0 || l1d_ack_out !== 1'b0) begin
            n_fail++; $display("FAIL rst_drop_req: req=%b ack=%b required 0 0", mem_req_out, l1d_ack_out);
        end
        rst = 1'b0; mem_ack_in = 1'b1; mem_rdata_in = 32'hCAFEF00D;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_ack_in = 1'b0;
            n_checks++;
            if (l1d_ack_out !== 1'b0 || mem_req_out !== 1'b0 || l1d_stall_out !== 1'b0) begin
                n_fail++;
                $display("FAIL late_ack_ignored: ack=%b req=%b stall=%b required 0 0 0",
                         l1d_ack_out, mem_req_out, l1d_stall_out);
            end
        end
        run_req(32'h900, 3'b100, 1'b0, 32'h0, 32'h0BADF00D, 2);
    endtask

    task automatic test_back_to_back_random();
        logic [2:0] sizes [9];
        logic [2:0] sz;
        sizes = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b011, 3'b000, 3'b110};
        for (int n = 0; n < 40; n++) begin
            sz = sizes[$urandom_range(0, 8)];
            run_req($urandom, sz, 1'($urandom_range(0, 1)), $urandom, $urandom,
                    int'($urandom_range(0, 6)) - 1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_reset_mid_req();
        test_back_to_back_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_l1d_resp.md
# core_l1d_resp

Data-side L1 responder for the Selen core. It accepts the load/store request that the execute stage registers toward memory: `l1d_val`, `l1d_cop`, `l1d_size`, address and store data. It converts each request into a single word-aligned, byte-enabled transaction on the data-memory bus. It stalls the memory stage until the bus acknowledges, then returns lane-aligned, zero-extended load data; sign extension stays in the write-back `wb_sx_op` path. Misaligned accesses and bus timeouts complete with an error flag instead of hanging the pipeline.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum number of cycles spent in REQ waiting for `mem_ack_in`. 0 disables the timeout.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: core clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `l1d_val_in` in 1: request valid; held stable by the core while `l1d_stall_out`=1.
- `l1d_cop_in` in 1: 0 = load, 1 = store.
- `l1d_size_in` in 3: one-hot size; 3'b001 = byte, 3'b010 = half, 3'b100 = word.
- `l1d_addr_in` in 32: byte address.
- `l1d_wdata_in` in 32: store data, right-justified.
- `l1d_stall_out` out 1: freeze the memory stage.
- `l1d_ack_out` out 1: one-cycle completion pulse.
- `l1d_err_out` out 1: valid with `l1d_ack_out`; 1 = misaligned, bad size, or timeout.
- `l1d_rdata_out` out 32: load result, valid with `l1d_ack_out`.
- `mem_req_out` out 1: bus request.
- `mem_we_out` out 1: bus write enable.
- `mem_be_out` out 4: bus byte enables.
- `mem_addr_out` out 32: word address; bits [1:0] = 0.
- `mem_wdata_out` out 32: bus write data, lane-replicated.
- `mem_ack_in` in 1: bus completion.
- `mem_rdata_in` in 32: bus read word, valid with `mem_ack_in`.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - On `l1d_val_in`=1 with a legal request → REQ. Register all `mem_*` outputs and assert `mem_req_out`.
  - On an illegal request → RESP with the error flag set. `mem_req_out` stays 0.
  - Otherwise stay in IDLE.
- Illegal request is any of:
  - size not one-hot;
  - half with addr[0]=1;
  - word with addr[1:0]≠0.
- REQ:
  - `mem_*` outputs are held constant.
  - On `mem_ack_in`=1: capture the read data and → RESP. `mem_req_out` drops at that edge.
  - Otherwise increment the wait counter. When the counter equals `TIMEOUT` (and `TIMEOUT`≠0): drop `mem_req_out`, → RESP with the error flag set and rdata = 0.
- RESP:
  - `l1d_ack_out`=1 and `l1d_stall_out`=0; the core advances on this edge.
  - `l1d_val_in` is ignored in RESP.
  - → IDLE unconditionally. The wait counter clears.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << {addr[1],1'b0}`
  - word: `4'b1111`
- Write data:
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: `wdata` unchanged.
- Load data:
  - Shift `mem_rdata_in` right by addr[1:0]×8.
  - Zero-extend to 32 bits: byte keeps [7:0], half keeps [15:0].
  - Stores return `l1d_rdata_out` = 0.
- `mem_ack_in` outside REQ is ignored: no state change, no counter change.
- `l1d_stall_out` is combinational: `(IDLE & l1d_val_in) | REQ`.

## Timing
- Reset values: state IDLE, counter 0. All outputs are 0: `l1d_ack_out`, `l1d_err_out`, `l1d_rdata_out`, and all `mem_*` outputs.
- Reset mid-REQ: `mem_req_out`=0 from the first edge with `rst`=1. A late `mem_ack_in` after reset is ignored. No ack is issued to the core.
- Legal request, zero-wait bus:
  - cycle 0: IDLE, stall=1;
  - cycle 1: REQ, `mem_req_out`=1, `mem_ack_in`=1;
  - cycle 2: RESP, ack=1.
  - Occupancy 3 cycles; stall high for 2.
- Each bus wait state adds 1 cycle to the REQ phase.
- Illegal request: cycle 0 IDLE, cycle 1 RESP with err=1. No bus activity.
- Timeout: the error RESP occurs in the cycle after REQ cycle `TIMEOUT`.
- Ack arriving in the same cycle the counter hits `TIMEOUT`: the ack wins; normal completion with err=0.
- Back-to-back requests: the next request is first sampled in the IDLE cycle after RESP. No overlapping bus requests.

## Test plan
- Word load: addr 0x100, bus returns 0xDEADBEEF after 0 waits.
  - Bus: `mem_addr_out`=0x100, be=4'b1111, we=0.
  - Core: ack in cycle 2 with rdata=0xDEADBEEF, err=0.
- Byte store: addr 0x203, wdata 0x000000A5.
  - Bus: `mem_addr_out`=0x200, be=4'b1000, `mem_wdata_out`=0xA5A5A5A5, we=1.
  - Core: ack with rdata=0.
- Half load: addr 0x302, bus returns 0x8001_1234.
  - Core: rdata=0x00008001.
- Misaligned word load at 0x401:
  - Core: ack+err in cycle 1; `mem_req_out` never asserted.
- Timeout with `TIMEOUT`=4, bus silent:
  - Bus: `mem_req_out` high for exactly 4 cycles.
  - Core: ack+err in the following cycle.
- `rst` pulsed during REQ with a 3-wait bus:
  - `mem_req_out` falls on that edge and the late ack is ignored.
  - A subsequent word load completes normally.
